btb_param: RTL and testbench
============================

BTB_PARAM -- requirements
Module: btb_param

Interface
REQ-001 SHALL have parameter N, default 3: fetch ports.
REQ-002 SHALL have parameter NUM_SETS, default 16, power of 2; IDX_W = log2(NUM_SETS).
REQ-003 SHALL have parameter NUM_WAYS, default 4, power of 2, >=2; AGE_W = log2(NUM_WAYS).
REQ-004 SHALL have parameter TAG_W, default 8: stored tag bits.
REQ-005 SHALL have the port clock, input, 1 bit: rising-edge clock.
REQ-006 SHALL have the port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have the port fetch_PCs, input, N x 32: lookup PCs.
REQ-008 SHALL have the port target_PCs, output, N x 32: predicted targets; 0 on miss.
REQ-009 SHALL have the port btb_hits, output, N: per-port hit.
REQ-010 SHALL have the port resolving_valid, input, 1: a branch resolves this cycle.
REQ-011 SHALL have the port resolving_branch_PC, input, 32: PC of the resolving branch.
REQ-012 SHALL have the port resolving_target_PC, input, 32: resolved target.
REQ-013 SHALL have the port resolving_taken, input, 1: resolved direction.
REQ-014 SHALL have the port flush_req, input, 1: one-cycle pulse that starts an invalidate-all.
REQ-015 SHALL have the port flush_busy, output, 1: a flush sweep is in progress.
REQ-016 SHALL have the port flush_done, output, 1: one-cycle pulse on the final sweep cycle.

Function
REQ-017 SHALL decode every PC as set = PC[IDX_W+1:2] and tag = PC[IDX_W+TAG_W+1:IDX_W+2]; PC[1:0] is ignored.
REQ-018 SHALL hold per entry: valid, tag, target (32 bits), age (AGE_W bits), conf (2-bit saturating).
REQ-019 SHALL produce lookups combinationally from registered state only; a resolve write becomes visible on the cycle after the edge that captures it.
REQ-020 SHALL report a hit on port i only when a way in set(i) has valid=1 and a matching tag; target_PCs[i] SHALL then be that way's target, else 0.
REQ-021 SHALL assert all N hits together when N ports hit the same entry, with no port interaction.
REQ-022 SHALL keep ages within a set as a permutation of 0..NUM_WAYS-1 at all times; 0 = LRU, NUM_WAYS-1 = MRU.
REQ-023 On resolve, taken, hit on way h: SHALL write the target, set conf = min(conf+1, 3), and promote h.
REQ-024 On resolve, taken, miss: SHALL select victim v as the lowest-index invalid way, else the way with age 0; then write valid=1, tag, target, conf=2, and promote v.
REQ-025 Promote(w): every way with age > old age[w] SHALL decrement its age (valid or not), and age[w] SHALL become NUM_WAYS-1.
REQ-026 On resolve, not taken, hit on way h: SHALL decrement conf; when conf reaches 0, valid SHALL clear; ages SHALL NOT change.
REQ-027 On resolve, not taken, miss: SHALL leave state unchanged.
REQ-028 Resolves SHALL touch only the addressed set; other sets hold their values.
REQ-029 SHALL implement a flush FSM with states IDLE and SWEEP.
REQ-030 IDLE -> SWEEP SHALL occur on flush_req, clearing a set counter to 0.
REQ-031 In SWEEP, one set per cycle at counter c SHALL get valid=0, conf=0 and age[w]=w; the counter SHALL increment.
REQ-032 SWEEP SHALL last exactly NUM_SETS cycles; flush_done SHALL pulse on the cycle c = NUM_SETS-1, followed by a return to IDLE.
REQ-033 During SWEEP: flush_busy=1, all btb_hits=0 and all target_PCs=0; resolves SHALL be ignored; flush_req SHALL be ignored.
REQ-034 flush_req arriving in the same cycle as resolving_valid in IDLE: the resolve SHALL be dropped and the sweep SHALL start.

Reset
REQ-035 On reset, every entry SHALL get valid=0, tag=0, target=0, conf=0 and age[w]=w in every set.
REQ-036 On reset, the FSM SHALL go to IDLE with the counter at 0.
REQ-037 On reset, outputs SHALL be: btb_hits=0, target_PCs=0, flush_busy=0, flush_done=0.
REQ-038 Reset asserted mid-SWEEP SHALL abort the sweep with no flush_done pulse.
REQ-039 Reset SHALL take priority over flush_req and resolving_valid.

Verification (defaults)
REQ-040 Resolve taken, PC 0x40, target 0x1000 -> next cycle fetch 0x40 gives hit=1, target 0x1000; fetch 0x44 (set 1) gives hit=0.
REQ-041 Five taken resolves to set 0 (PCs 0x40, 0x80, 0xC0, 0x100, 0x140) -> 0x40 is evicted (miss); the other four hit.
REQ-042 Insert 0x40 (conf=2), then two not-taken resolves -> hit after the first, miss after the second; a third not-taken leaves state unchanged.
REQ-043 Fill set 0 with 0x40..0x100, re-resolve 0x40 taken, then insert 0x140 -> 0x80 is evicted and 0x40 survives.
REQ-044 Populate sets 0..3, then pulse flush_req -> flush_busy high for 16 cycles, flush_done on the 16th, all lookups miss afterwards; a resolve during the sweep has no effect.
REQ-045 Reset asserted at sweep cycle 5 -> next cycle flush_busy=0, no flush_done pulse, all lookups miss.

Source files
------------

// File: rtl/btb_param_if.sv
// Bus bundle for btb_param: multi-port fetch lookup, branch resolution and flush control.
interface btb_param_if #(
    parameter int N = 3
);
    logic [N-1:0][31:0] fetch_PCs;
    logic [N-1:0][31:0] target_PCs;
    logic [N-1:0]       btb_hits;
    logic               resolving_valid;
    logic [31:0]        resolving_branch_PC;
    logic [31:0]        resolving_target_PC;
    logic               resolving_taken;
    logic               flush_req;
    logic               flush_busy;
    logic               flush_done;

    modport master (
        output fetch_PCs, resolving_valid, resolving_branch_PC, resolving_target_PC,
               resolving_taken, flush_req,
        input  target_PCs, btb_hits, flush_busy, flush_done
    );

    modport slave (
        input  fetch_PCs, resolving_valid, resolving_branch_PC, resolving_target_PC,
               resolving_taken, flush_req,
        output target_PCs, btb_hits, flush_busy, flush_done
    );
endinterface

// File: rtl/btb_param.sv
// Set-associative branch target buffer with N lookup ports, LRU-age replacement,
// 2-bit confidence and a one-set-per-cycle flush sweep.
module btb_param #(
    parameter int N        = 3,
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    parameter int TAG_W    = 8
) (
    input logic        clock,
    input logic        reset,
    btb_param_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int AGE_W = $clog2(NUM_WAYS);
    localparam logic [AGE_W-1:0] AGE_MRU  = AGE_W'(NUM_WAYS - 1);
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             flush_done_s;

    logic             valid_q  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0] tag_q    [NUM_SETS][NUM_WAYS];
    logic [31:0]      target_q [NUM_SETS][NUM_WAYS];
    logic [AGE_W-1:0] age_q    [NUM_SETS][NUM_WAYS];
    logic [1:0]       conf_q   [NUM_SETS][NUM_WAYS];

    logic             row_valid_d  [NUM_WAYS];
    logic [TAG_W-1:0] row_tag_d    [NUM_WAYS];
    logic [31:0]      row_target_d [NUM_WAYS];
    logic [AGE_W-1:0] row_age_d    [NUM_WAYS];
    logic [1:0]       row_conf_d   [NUM_WAYS];
    logic             row_we_s;

    logic [IDX_W-1:0] res_set_s;
    logic [TAG_W-1:0] res_tag_s;
    logic             res_hit_s, inv_found_s, promote_s;
    logic [AGE_W-1:0] res_way_s, inv_way_s, lru_way_s, victim_s, prom_way_s, old_age_s;

    logic [IDX_W-1:0] fetch_set_s [N];
    logic [TAG_W-1:0] fetch_tag_s [N];
    logic [N-1:0]       hits_s;
    logic [N-1:0][31:0] targets_s;
    logic               unused_pc_bits_s;

    assign res_set_s = bus.resolving_branch_PC[IDX_W+1:2];
    assign res_tag_s = bus.resolving_branch_PC[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_pc_bits_s = ^{bus.fetch_PCs, bus.resolving_branch_PC};

    for (genvar i = 0; i < N; i++) begin : g_dec
        assign fetch_set_s[i] = bus.fetch_PCs[i][IDX_W+1:2];
        assign fetch_tag_s[i] = bus.fetch_PCs[i][IDX_W+TAG_W+1:IDX_W+2];
    end

    // Flush FSM next-state: one set per cycle, done pulse on the last set.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_done_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (cnt_q == LAST_SET) begin
                    flush_done_s = 1'b1;
                    state_d      = IDLE;
                    cnt_d        = '0;
                end else begin
                    state_d = SWEEP;
                    cnt_d   = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Resolve path: way search, victim choice and new contents of the addressed set.
    always_comb begin
        res_hit_s   = 1'b0;
        res_way_s   = '0;
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        lru_way_s   = '0;
        // Scan downward so the lowest-index candidate is the one that sticks.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[res_set_s][w] && (tag_q[res_set_s][w] == res_tag_s)) begin
                res_hit_s = 1'b1;
                res_way_s = AGE_W'(w);
            end else begin
                res_hit_s = res_hit_s;
            end
            if (!valid_q[res_set_s][w]) begin
                inv_found_s = 1'b1;
                inv_way_s   = AGE_W'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
            if (age_q[res_set_s][w] == '0) begin
                lru_way_s = AGE_W'(w);
            end else begin
                lru_way_s = lru_way_s;
            end
        end
        victim_s = inv_found_s ? inv_way_s : lru_way_s;

        for (int w = 0; w < NUM_WAYS; w++) begin
            row_valid_d[w]  = valid_q[res_set_s][w];
            row_tag_d[w]    = tag_q[res_set_s][w];
            row_target_d[w] = target_q[res_set_s][w];
            row_age_d[w]    = age_q[res_set_s][w];
            row_conf_d[w]   = conf_q[res_set_s][w];
        end
        row_we_s   = 1'b0;
        promote_s  = 1'b0;
        prom_way_s = '0;

        if ((state_q == IDLE) && !bus.flush_req && bus.resolving_valid) begin
            if (bus.resolving_taken) begin
                row_we_s  = 1'b1;
                promote_s = 1'b1;
                if (res_hit_s) begin
                    prom_way_s                = res_way_s;
                    row_target_d[res_way_s]   = bus.resolving_target_PC;
                    row_conf_d[res_way_s]     = (conf_q[res_set_s][res_way_s] == 2'd3) ?
                                                2'd3 : conf_q[res_set_s][res_way_s] + 2'd1;
                end else begin
                    prom_way_s               = victim_s;
                    row_valid_d[victim_s]    = 1'b1;
                    row_tag_d[victim_s]      = res_tag_s;
                    row_target_d[victim_s]   = bus.resolving_target_PC;
                    row_conf_d[victim_s]     = 2'd2;
                end
            end else if (res_hit_s) begin
                row_we_s                = 1'b1;
                row_conf_d[res_way_s]   = (conf_q[res_set_s][res_way_s] == 2'd0) ?
                                          2'd0 : conf_q[res_set_s][res_way_s] - 2'd1;
                row_valid_d[res_way_s]  = (conf_q[res_set_s][res_way_s] > 2'd1);
            end else begin
                row_we_s = 1'b0;
            end
        end else begin
            row_we_s = 1'b0;
        end

        old_age_s = age_q[res_set_s][prom_way_s];
        if (promote_s) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                row_age_d[w] = (age_q[res_set_s][w] > old_age_s) ?
                               age_q[res_set_s][w] - AGE_W'(1) : age_q[res_set_s][w];
            end
            row_age_d[prom_way_s] = AGE_MRU;
        end else begin
            promote_s = 1'b0;
        end
    end

    // Lookup path: combinational read of registered state, forced to miss while sweeping.
    always_comb begin
        hits_s    = '0;
        targets_s = '0;
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if ((state_q == IDLE) && valid_q[fetch_set_s[i]][w] &&
                    (tag_q[fetch_set_s[i]][w] == fetch_tag_s[i])) begin
                    hits_s[i]    = 1'b1;
                    targets_s[i] = target_q[fetch_set_s[i]][w];
                end else begin
                    hits_s[i] = hits_s[i];
                end
            end
        end
    end

    // State register for the flush FSM and all BTB entries.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= 32'h0000_0000;
                    age_q[s][w]    <= AGE_W'(w);
                    conf_q[s][w]   <= 2'd0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == SWEEP) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[cnt_q][w] <= 1'b0;
                    conf_q[cnt_q][w]  <= 2'd0;
                    age_q[cnt_q][w]   <= AGE_W'(w);
                end
            end else if (row_we_s) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[res_set_s][w]  <= row_valid_d[w];
                    tag_q[res_set_s][w]    <= row_tag_d[w];
                    target_q[res_set_s][w] <= row_target_d[w];
                    age_q[res_set_s][w]    <= row_age_d[w];
                    conf_q[res_set_s][w]   <= row_conf_d[w];
                end
            end
        end
    end

    assign bus.btb_hits   = hits_s;
    assign bus.target_PCs = targets_s;
    assign bus.flush_busy = (state_q == SWEEP);
    assign bus.flush_done = flush_done_s;
endmodule

// File: tb/tb_btb_param.sv
// Self-checking bench for btb_param: table of resolve/lookup vectors plus flush and reset sequences.
module tb_btb_param;
    localparam int N = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    btb_param_if #(.N(N)) bus ();
    btb_param #(.N(N), .NUM_SETS(16), .NUM_WAYS(4), .TAG_W(8)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    typedef struct packed {
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] rtgt;
        logic        rtk;
        logic [2:0][31:0] lpc;
        logic [2:0]       ehit;
        logic [2:0][31:0] etgt;
    } vec_t;

    typedef struct {
        string       nm;
        int          port;
        logic        hit;
        logic [31:0] tgt;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic [31:0] rtgt,
                                input logic rtk,
                                input logic [31:0] l0, input logic h0, input logic [31:0] t0,
                                input logic [31:0] l1, input logic h1, input logic [31:0] t1,
                                input logic [31:0] l2, input logic h2, input logic [31:0] t2);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rtgt = rtgt; v.rtk = rtk;
        v.lpc  = {l2, l1, l0};
        v.ehit = {h2, h1, h0};
        v.etgt = {t2, t1, t0};
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    endtask

    // Drive three lookups, queue expectations, then drain the scoreboard against DUT outputs.
    task automatic lookup3(input string nm, input logic [2:0][31:0] pcs,
                           input logic [2:0] eh, input logic [2:0][31:0] et);
        sb_t e;
        bus.fetch_PCs = pcs;
        for (int p = 0; p < N; p++) sb_q.push_back('{nm, p, eh[p], et[p]});
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.nm, e.port, {31'd0, bus.btb_hits[e.port], bus.target_PCs[e.port]},
                {31'd0, e.hit, e.tgt});
        end
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        bus.resolving_valid     = 1'b1;
        bus.resolving_branch_PC = pc;
        bus.resolving_target_PC = tgt;
        bus.resolving_taken     = tk;
        @(negedge clock);
        bus.resolving_valid = 1'b0;
    endtask

    task automatic all_miss(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c);
        lookup3(nm, {c, b, a}, 3'b000, {32'h0, 32'h0, 32'h0});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int done_seen;
        reset = 1'b1;
        bus.fetch_PCs = '0;
        bus.resolving_valid = 1'b0; bus.resolving_branch_PC = 32'h0;
        bus.resolving_target_PC = 32'h0; bus.resolving_taken = 1'b0;
        bus.flush_req = 1'b0;

        vecs.push_back(mk(1'b1, 32'h40, 32'h1000, 1'b1, 32'h40, 1'b1, 32'h1000, 32'h44, 1'b0, 32'h0, 32'h42, 1'b1, 32'h1000));
        vecs.push_back(mk(1'b1, 32'h80, 32'h2000, 1'b1, 32'h80, 1'b1, 32'h2000, 32'h40, 1'b1, 32'h1000, 32'hC0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'hC0, 32'h3000, 1'b1, 32'hC0, 1'b1, 32'h3000, 32'h80, 1'b1, 32'h2000, 32'h100, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h100, 32'h4000, 1'b1, 32'h100, 1'b1, 32'h4000, 32'h40, 1'b1, 32'h1000, 32'h140, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h140, 32'h5000, 1'b1, 32'h40, 1'b0, 32'h0, 32'h140, 1'b1, 32'h5000, 32'hC0, 1'b1, 32'h3000));
        vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h80, 1'b1, 32'h2000, 32'h100, 1'b1, 32'h4000, 32'h44, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h48, 32'h6000, 1'b1, 32'h48, 1'b1, 32'h6000, 32'h140, 1'b1, 32'h5000, 32'h4C, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h48, 32'h0, 1'b0, 32'h48, 1'b1, 32'h6000, 32'h48, 1'b1, 32'h6000, 32'h48, 1'b1, 32'h6000));
        vecs.push_back(mk(1'b1, 32'h48, 32'h0, 1'b0, 32'h48, 1'b0, 32'h0, 32'h140, 1'b1, 32'h5000, 32'h80, 1'b1, 32'h2000));
        vecs.push_back(mk(1'b1, 32'h48, 32'h0, 1'b0, 32'h48, 1'b0, 32'h0, 32'h4C, 1'b0, 32'h0, 32'h40, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 32'h7000, 1'b1, 32'h4C, 1'b1, 32'h7000, 32'h48, 1'b0, 32'h0, 32'h140, 1'b1, 32'h5000));
        vecs.push_back(mk(1'b1, 32'h4C, 32'h7100, 1'b1, 32'h4C, 1'b1, 32'h7100, 32'h4C, 1'b1, 32'h7100, 32'h4C, 1'b1, 32'h7100));
        vecs.push_back(mk(1'b1, 32'h4C, 32'h7200, 1'b1, 32'h4C, 1'b1, 32'h7200, 32'h4C, 1'b1, 32'h7200, 32'h4C, 1'b1, 32'h7200));
        vecs.push_back(mk(1'b1, 32'h4C, 32'h0, 1'b0, 32'h4C, 1'b1, 32'h7200, 32'h4C, 1'b1, 32'h7200, 32'h4C, 1'b1, 32'h7200));
        vecs.push_back(mk(1'b1, 32'h4C, 32'h0, 1'b0, 32'h4C, 1'b1, 32'h7200, 32'h4C, 1'b1, 32'h7200, 32'h4C, 1'b1, 32'h7200));
        vecs.push_back(mk(1'b1, 32'h4C, 32'h0, 1'b0, 32'h4C, 1'b0, 32'h0, 32'h4C, 1'b0, 32'h0, 32'h4C, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h44, 32'h8000, 1'b1, 32'h44, 1'b1, 32'h8000, 32'h84, 1'b0, 32'h0, 32'h4C, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h84, 32'h8100, 1'b1, 32'h84, 1'b1, 32'h8100, 32'h44, 1'b1, 32'h8000, 32'hC4, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'hC4, 32'h8200, 1'b1, 32'hC4, 1'b1, 32'h8200, 32'h104, 1'b0, 32'h0, 32'h44, 1'b1, 32'h8000));
        vecs.push_back(mk(1'b1, 32'h104, 32'h8300, 1'b1, 32'h44, 1'b1, 32'h8000, 32'h84, 1'b1, 32'h8100, 32'h104, 1'b1, 32'h8300));
        vecs.push_back(mk(1'b1, 32'h44, 32'h8800, 1'b1, 32'h44, 1'b1, 32'h8800, 32'hC4, 1'b1, 32'h8200, 32'h84, 1'b1, 32'h8100));
        vecs.push_back(mk(1'b1, 32'h144, 32'h8400, 1'b1, 32'h84, 1'b0, 32'h0, 32'h44, 1'b1, 32'h8800, 32'h144, 1'b1, 32'h8400));
        vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'hC4, 1'b1, 32'h8200, 32'h104, 1'b1, 32'h8300, 32'h140, 1'b1, 32'h5000));

        // Reset state: tag-0 entries must not hit, status outputs low.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        all_miss("reset_lookup", 32'h0, 32'h4, 32'h40);
        chk("reset_busy", 0, {63'd0, bus.flush_busy}, 64'd0);
        chk("reset_done", 0, {63'd0, bus.flush_done}, 64'd0);

        for (int r = 0; r < vecs.size(); r++) begin
            if (vecs[r].rv) resolve(vecs[r].rpc, vecs[r].rtgt, vecs[r].rtk);
            else @(negedge clock);
            lookup3($sformatf("vec%0d", r), vecs[r].lpc, vecs[r].ehit, vecs[r].etgt);
        end

        // Flush sweep with a resolve and a second flush_req landing mid-sweep.
        resolve(32'h48, 32'h9000, 1'b1);
        resolve(32'h4C, 32'h9100, 1'b1);
        lookup3("pre_flush", {32'h4C, 32'h48, 32'h140}, 3'b111, {32'h9100, 32'h9000, 32'h5000});
        bus.flush_req = 1'b1;
        bus.resolving_valid = 1'b1; bus.resolving_branch_PC = 32'h1C4;
        bus.resolving_target_PC = 32'hA100; bus.resolving_taken = 1'b1;
        @(negedge clock);
        bus.flush_req = 1'b0;
        bus.resolving_valid = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 16; k++) begin
            all_miss("sweep_lookup", 32'h140, 32'h48, 32'h4C);
            chk("sweep_busy", k, {63'd0, bus.flush_busy}, 64'd1);
            chk("sweep_done", k, {63'd0, bus.flush_done}, {63'd0, (k == 15)});
            if (k == 3) begin
                bus.resolving_valid = 1'b1; bus.resolving_branch_PC = 32'h1C0;
                bus.resolving_target_PC = 32'hA000; bus.resolving_taken = 1'b1;
            end else if (k == 5) begin
                bus.resolving_valid = 1'b0;
                bus.flush_req = 1'b1;
            end else begin
                bus.resolving_valid = 1'b0;
                bus.flush_req = 1'b0;
            end
            @(negedge clock);
        end
        bus.flush_req = 1'b0;
        all_miss("post_flush", 32'h140, 32'h1C0, 32'h1C4);
        all_miss("post_flush2", 32'h44, 32'h48, 32'h4C);
        chk("post_busy", 0, {63'd0, bus.flush_busy}, 64'd0);
        chk("post_done", 0, {63'd0, bus.flush_done}, 64'd0);

        resolve(32'h40, 32'hB000, 1'b1);
        resolve(32'h60, 32'hC000, 1'b1);
        lookup3("refill", {32'h60, 32'h40, 32'h80}, 3'b110, {32'hC000, 32'hB000, 32'h0});

        // Reset at sweep cycle 5 with flush_req and a resolve pending in the same cycle.
        bus.flush_req = 1'b1;
        @(negedge clock);
        bus.flush_req = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        chk("abort_busy_pre", 0, {63'd0, bus.flush_busy}, 64'd1);
        reset = 1'b1;
        bus.flush_req = 1'b1;
        bus.resolving_valid = 1'b1; bus.resolving_branch_PC = 32'h64;
        bus.resolving_target_PC = 32'hD000; bus.resolving_taken = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.flush_req = 1'b0;
        bus.resolving_valid = 1'b0;
        all_miss("abort_lookup", 32'h60, 32'h40, 32'h64);
        chk("abort_busy", 0, {63'd0, bus.flush_busy}, 64'd0);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.flush_done || bus.flush_busy) done_seen++;
            @(negedge clock);
        end
        chk("abort_no_done", 0, done_seen, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
